store_merge_unit: RTL and testbench

- Store-path counterpart of the load extender: merges a register value into a 64-bit memory doubleword for SD, SW, SH and SB, then writes the doubleword back.
- Sits between the register-file read port (rs2 data) and the data-memory port of the multicycle CPU, and is started by the control FSM.
- Partial stores use read-modify-write: read the doubleword, replace its low-order bytes, write it back. SD writes directly with no read.

---
 rtl/store_merge_unit.sv | 166 ++++++++++++++++
 tb/tb_store_merge_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store merge unit: read-modify-write of a 64-bit doubleword for SD/SW/SH/SB.
// Optional last-write bypass enabled by defining STORE_MERGE_BYPASS_EN.
module store_merge_unit #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        Seletor,
    input  logic [DATA_W-1:0] Addr,
    input  logic [DATA_W-1:0] Reg_data,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [DATA_W-1:0] Mem_addr,
    output logic              Mem_rd,
    output logic              Mem_wr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (DATA_W != 64 || MEM_LAT < 1 || MEM_LAT > 15) begin : gen_bad_param
        $error("store_merge_unit: DATA_W must be 64 and MEM_LAT in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] reg_q, reg_d;
    logic [2:0]        sel_q, sel_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_res;

`ifdef STORE_MERGE_BYPASS_EN
    logic              byp_valid_q;
    logic [DATA_W-1:0] byp_addr_q;
    logic [DATA_W-1:0] byp_data_q;
    logic              byp_hit;
`endif

    // Replace only the low-order bytes of the doubleword; SD takes the register whole.
    function automatic logic [DATA_W-1:0] merge(input logic [2:0]        sel,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] r);
        case (sel)
            3'd1:    merge = {b[63:32], r[31:0]};
            3'd2:    merge = {b[63:16], r[15:0]};
            3'd3:    merge = {b[63:8], r[7:0]};
            default: merge = r;
        endcase
    endfunction

    assign merge_res = merge(sel_q, buf_q, reg_q);

`ifdef STORE_MERGE_BYPASS_EN
    assign byp_hit = byp_valid_q && (byp_addr_q == Addr);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        reg_d    = reg_q;
        sel_d    = sel_q;
        err_d    = err_q;
        buf_d    = buf_q;
        wdata_d  = wdata_q;
        Mem_rd   = 1'b0;
        Mem_wr   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        Mem_addr = addr_q;
        Mem_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    addr_d = Addr;
                    reg_d  = Reg_data;
                    sel_d  = Seletor;
                    err_d  = 1'b0;
                    cnt_d  = 4'd0;
                    if (Seletor > 3'd3) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (Seletor == 3'd0) begin
                        state_d = StWrite;
`ifdef STORE_MERGE_BYPASS_EN
                    end else if (byp_hit) begin
                        buf_d   = byp_data_q;
                        state_d = StWrite;
`endif
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                Mem_rd = 1'b1;
                if (cnt_q == LastCnt) begin
                    buf_d   = Mem_rdata;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrite: begin
                Mem_wr    = 1'b1;
                Mem_wdata = merge_res;
                wdata_d   = merge_res;
                state_d   = StDone;
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef STORE_MERGE_BYPASS_EN
    // Only this unit writes data memory, so the last written doubleword stays coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            byp_valid_q <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
        end else if (state_q == StWrite) begin
            byp_valid_q <= 1'b1;
            byp_addr_q  <= addr_q;
            byp_data_q  <= merge_res;
        end
    end
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit, run on MEM_LAT=1 and MEM_LAT=4 instances.
module tb_store_merge_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit fin [2];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        int          rd_n;
        int          wr_n;
        logic        err;
        int          lat;
    } exp_t;

    task automatic check(input int lat, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL lat%0d %s: got 0x%0h expected 0x%0h", lat, name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] wd, input int rd_n,
                                input int wr_n, input logic e, input int lat);
        exp_t x;
        x.addr = a; x.wdata = wd; x.rd_n = rd_n; x.wr_n = wr_n; x.err = e; x.lat = lat;
        return x;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 4;
        localparam int L = int'(LAT);

        logic        reset, start, mem_rd, mem_wr, busy, done, err;
        logic [2:0]  sel;
        logic [63:0] addr, reg_data, mem_rdata, mem_addr, mem_wdata;
        logic [63:0] mem [4];
        logic        pre_en = 1'b0;
        logic [1:0]  pre_idx = '0;
        logic [63:0] pre_val = '0;
        int          rd_run = 0;
        exp_t        exp_q[$];

        store_merge_unit #(.MEM_LAT(LAT), .DATA_W(64)) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .Seletor  (sel),
            .Addr     (addr),
            .Reg_data (reg_data),
            .Mem_rdata(mem_rdata),
            .Mem_addr (mem_addr),
            .Mem_rd   (mem_rd),
            .Mem_wr   (mem_wr),
            .Mem_wdata(mem_wdata),
            .busy     (busy),
            .done     (done),
            .err      (err)
        );

        // Memory: data is only valid on the LAT-th consecutive read cycle.
        always @(posedge clk) begin
            rd_run <= mem_rd ? rd_run + 1 : 0;
            if (mem_wr) mem[mem_addr[7:6]] <= mem_wdata;
            else if (pre_en) mem[pre_idx] <= pre_val;
        end
        assign mem_rdata = (mem_rd && rd_run == L - 1) ? mem[mem_addr[7:6]]
                                                       : 64'hDEAD_BEEF_DEAD_BEEF;

        exp_t        e;
        int          t0 = 0, rd_n = 0, wr_n = 0;
        logic [63:0] wd = '0, wa = '0, ra = '0;
        bit          active = 0, ov = 0, stray = 0;

        always @(negedge clk) begin
            if (reset) begin
                active = 0;
            end else begin
                if (start && !busy) begin
                    active = 1; t0 = cyc; rd_n = 0; wr_n = 0; ov = 0;
                end
                if (!active && (mem_rd || mem_wr)) stray = 1;
                if (mem_rd) begin rd_n++; ra = mem_addr; end
                if (mem_wr) begin wr_n++; wd = mem_wdata; wa = mem_addr; end
                if (mem_rd && mem_wr) ov = 1;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check(L, "unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(L, "latency", cyc - t0, e.lat);
                        check(L, "rd_cycles", rd_n, e.rd_n);
                        check(L, "wr_cycles", wr_n, e.wr_n);
                        check(L, "err", err, e.err);
                        check(L, "rd_wr_overlap", ov, 0);
                        if (e.wr_n > 0) begin
                            check(L, "wdata", wd, e.wdata);
                            check(L, "wr_addr", wa, e.addr);
                        end
                        if (e.rd_n > 0) check(L, "rd_addr", ra, e.addr);
                    end
                    active = 0;
                end
            end
        end

        task automatic preload(input logic [1:0] idx, input logic [63:0] v);
            pre_idx = idx; pre_val = v; pre_en = 1'b1;
            @(posedge clk); #1;
            pre_en = 1'b0;
        endtask

        task automatic issue(input logic [2:0] s, input logic [63:0] a, input logic [63:0] r,
                             input bit push, input exp_t x);
            for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; end
            check(L, "idle_before_start", busy, 0);
            sel = s; addr = a; reg_data = r; start = 1'b1;
            if (push) exp_q.push_back(x);
            @(posedge clk); #1;
            start = 1'b0;
        endtask

        initial begin
            reset = 1'b1; start = 1'b0; sel = '0; addr = '0; reg_data = '0;
            repeat (3) @(posedge clk);
            #1;
            check(L, "rst_mem_addr", mem_addr, 0);
            check(L, "rst_mem_wdata", mem_wdata, 0);
            check(L, "rst_mem_rd", mem_rd, 0);
            check(L, "rst_mem_wr", mem_wr, 0);
            check(L, "rst_busy", busy, 0);
            check(L, "rst_done", done, 0);
            check(L, "rst_err", err, 0);
            preload(2'd2, 64'hAAAA_AAAA_5555_5555);
            preload(2'd3, 64'h0123_4567_89AB_CDEF);
            preload(2'd0, 64'h0123_4567_89AB_CDEF);
            reset = 1'b0;
            @(posedge clk); #1;

            issue(3'd0, 64'h40, 64'h1122_3344_5566_7788, 1,
                  mk(64'h40, 64'h1122_3344_5566_7788, 0, 1, 0, 2));
            issue(3'd1, 64'h80, 64'hFFFF_FFFF_CAFE_BABE, 1,
                  mk(64'h80, 64'hAAAA_AAAA_CAFE_BABE, L, 1, 0, L + 2));
`ifdef STORE_MERGE_BYPASS_EN
            issue(3'd3, 64'h80, 64'hEF, 1, mk(64'h80, 64'hAAAA_AAAA_CAFE_BAEF, 0, 1, 0, 2));
`else
            issue(3'd3, 64'h80, 64'hEF, 1, mk(64'h80, 64'hAAAA_AAAA_CAFE_BAEF, L, 1, 0, L + 2));
`endif
            issue(3'd2, 64'hC0, 64'hBEEF, 1,
                  mk(64'hC0, 64'h0123_4567_89AB_BEEF, L, 1, 0, L + 2));
            issue(3'd3, 64'h00, 64'hBEEF, 1,
                  mk(64'h00, 64'h0123_4567_89AB_CDEF, L, 1, 0, L + 2));
            issue(3'd5, 64'h40, 64'h0, 1, mk(64'h40, 64'h0, 0, 0, 1, 1));
            issue(3'd1, 64'h40, 64'h1234_5678, 1,
                  mk(64'h40, 64'h1122_3344_1234_5678, L, 1, 0, L + 2));
            // Busy now: this start must be dropped.
            sel = 3'd0; addr = 64'h40; reg_data = 64'h0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;

            issue(3'd1, 64'h80, 64'h0, 0, mk(64'h0, 64'h0, 0, 0, 0, 0));
            for (int i = 0; i < 100 && !mem_wr; i++) begin @(posedge clk); #1; end
            check(L, "reach_write", mem_wr, 1);
            reset = 1'b1;
            @(posedge clk); #1;
            check(L, "abort_mem_wr", mem_wr, 0);
            check(L, "abort_busy", busy, 0);
            check(L, "abort_done", done, 0);
            reset = 1'b0;
            @(posedge clk); #1;

            issue(3'd0, 64'h40, 64'hCAFE, 1, mk(64'h40, 64'hCAFE, 0, 1, 0, 2));
            for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
            repeat (5) @(posedge clk);
            check(L, "queue_drained", exp_q.size(), 0);
            check(L, "stray_strobe", stray, 0);
            fin[g] = 1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(fin[0] && fin[1]); i++) @(posedge clk);
        if (!(fin[0] && fin[1])) begin
            failures++;
            $display("FAIL timeout: got unfinished expected finished");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
